// File: rtl/simple_processor_pkg.sv
// Shared types and elaboration helpers for the simple processor execute stage.
package simple_processor_pkg;

    typedef enum logic [2:0] {
        SHIFT_SLL = 3'd0,
        SHIFT_SRL = 3'd1,
        SHIFT_SRA = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } shift_op_t;

    // Integer ceiling division, used to size the per-stage share of mux levels.
    function automatic int ceilDiv(input int numer, input int denom);
        return (numer + denom - 1) / denom;
    endfunction

    // Number of mux levels owned by one pipeline stage; trailing stages may own none.
    function automatic int stageLevels(input int stage, input int perStage, input int total);
        int firstLevel;
        int lastLevel;
        firstLevel = stage * perStage;
        lastLevel  = ((stage + 1) * perStage < total) ? (stage + 1) * perStage : total;
        return (lastLevel > firstLevel) ? (lastLevel - firstLevel) : 0;
    endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// One pipeline stage of the barrel shifter: a run of shift-by-power-of-two
// mux levels followed by a register slice with valid/ready flow control.
module alu_shift_stage
    import simple_processor_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_W     = 5,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [SHAMT_W-1:0]    i_shamt,
    input  shift_op_t             i_op,
    input  logic                  i_fill,
    output logic                  o_ready,
    input  logic                  i_downReady,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [SHAMT_W-1:0]    o_shamt,
    output shift_op_t             o_op,
    output logic                  o_fill
);

    // A single fixed-distance step of the requested operation. Chaining these
    // steps composes correctly for every op: rotates add up, and an arithmetic
    // shift keeps the original sign bit in the fill register across stages.
    function automatic logic [DATA_WIDTH-1:0] shiftLevel(
        input logic [DATA_WIDTH-1:0] data,
        input shift_op_t             op,
        input logic                  fill,
        input int                    amount
    );
        logic [DATA_WIDTH-1:0] fillMask;
        fillMask = {DATA_WIDTH{fill}} << (DATA_WIDTH - amount);
        case (op)
            SHIFT_SLL: shiftLevel = data << amount;
            SHIFT_SRA: shiftLevel = (data >> amount) | fillMask;
            SHIFT_ROL: shiftLevel = (data << amount) | (data >> (DATA_WIDTH - amount));
            SHIFT_ROR: shiftLevel = (data >> amount) | (data << (DATA_WIDTH - amount));
            default:   shiftLevel = data >> amount;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] w_level [NUM_LEVELS+1];
    logic                  w_load;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SHAMT_W-1:0]    r_shamt;
    shift_op_t             r_op;
    logic                  r_fill;

    assign w_level[0] = i_data;

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_level
        localparam int LEVEL = FIRST_LEVEL + g;
        assign w_level[g+1] = i_shamt[LEVEL]
                            ? shiftLevel(w_level[g], i_op, i_fill, 1 << LEVEL)
                            : w_level[g];
    end

    // The slice takes new content when it is empty or its content leaves this cycle.
    assign w_load  = !r_valid || i_downReady;
    assign o_ready = w_load;

    // Register slice; payload only changes when a valid request is captured,
    // so an emptied slot keeps its last value rather than toggling.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_op    <= SHIFT_SLL;
            r_fill  <= 1'b0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data  <= w_level[NUM_LEVELS];
                r_shamt <= i_shamt;
                r_op    <= i_op;
                r_fill  <= i_fill;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_op    = r_op;
    assign o_fill  = r_fill;

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined barrel shifter for the execute stage. Selects the shift amount,
// folds unknown opcodes onto SRL, and spreads the mux levels over a chain of
// register stages joined by valid/ready handshakes.
module alu_shift_pipe
    import simple_processor_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int IMM_WIDTH   = 6,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  shift_op_t             op_i,
    input  logic                  use_imm_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [IMM_WIDTH-1:0]  imm_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int SHAMT_W          = $clog2(DATA_WIDTH);
    localparam int LEVELS_PER_STAGE = ceilDiv(SHAMT_W, PIPE_STAGES);

    // Index 0 is the request side; index s+1 is the output of stage s.
    logic                  w_valid [PIPE_STAGES+1];
    logic                  w_ready [PIPE_STAGES+1];
    logic [DATA_WIDTH-1:0] w_data  [PIPE_STAGES+1];
    logic [SHAMT_W-1:0]    w_shamt [PIPE_STAGES+1];
    shift_op_t             w_op    [PIPE_STAGES+1];
    logic                  w_fill  [PIPE_STAGES+1];

    shift_op_t             w_opSel;
    logic                  w_unusedBits;

    // Encodings outside the defined set are treated as a logical right shift.
    always_comb begin
        w_opSel = SHIFT_SRL;
        case (op_i)
            SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL, SHIFT_ROR: w_opSel = op_i;
            default: w_opSel = SHIFT_SRL;
        endcase
    end

    // Only the low bits of the amount matter, which gives modulo-width semantics.
    assign w_valid[0] = in_valid_i;
    assign w_data[0]  = rs1_data_i;
    assign w_shamt[0] = use_imm_i ? imm_i[SHAMT_W-1:0] : rs2_data_i[SHAMT_W-1:0];
    assign w_op[0]    = w_opSel;
    assign w_fill[0]  = rs1_data_i[DATA_WIDTH-1];

    assign w_ready[PIPE_STAGES] = out_ready_i;
    assign in_ready_o           = w_ready[0];

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        alu_shift_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SHAMT_W     (SHAMT_W),
            .FIRST_LEVEL (s * LEVELS_PER_STAGE),
            .NUM_LEVELS  (stageLevels(s, LEVELS_PER_STAGE, SHAMT_W))
        ) u_stage (
            .i_clk       (clk_i),
            .i_arst      (arst_i),
            .i_valid     (w_valid[s]),
            .i_data      (w_data[s]),
            .i_shamt     (w_shamt[s]),
            .i_op        (w_op[s]),
            .i_fill      (w_fill[s]),
            .o_ready     (w_ready[s]),
            .i_downReady (w_ready[s+1]),
            .o_valid     (w_valid[s+1]),
            .o_data      (w_data[s+1]),
            .o_shamt     (w_shamt[s+1]),
            .o_op        (w_op[s+1]),
            .o_fill      (w_fill[s+1])
        );
    end

    assign out_valid_o = w_valid[PIPE_STAGES];
    assign result_o    = w_data[PIPE_STAGES];

    // Upper amount bits and the trailing control fields are intentionally dropped.
    assign w_unusedBits = ^{rs2_data_i, imm_i, w_shamt[PIPE_STAGES],
                            w_op[PIPE_STAGES], w_fill[PIPE_STAGES]};

`ifdef SIMULATION
    // Reject parameter combinations the level split cannot honour.
    initial begin
        if ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)
            $fatal(1, "alu_shift_pipe: DATA_WIDTH %0d is not a power of two", DATA_WIDTH);
        if (PIPE_STAGES < 1 || PIPE_STAGES > SHAMT_W)
            $fatal(1, "alu_shift_pipe: PIPE_STAGES %0d outside 1..%0d", PIPE_STAGES, SHAMT_W);
        if (IMM_WIDTH < SHAMT_W)
            $fatal(1, "alu_shift_pipe: IMM_WIDTH %0d narrower than %0d", IMM_WIDTH, SHAMT_W);
    end
`endif

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Scoreboard bench for alu_shift_pipe: accepted requests push a model result,
// a negedge monitor compares every presented output against the queue head.
module tb_alu_shift_pipe;
    import simple_processor_pkg::*;

    localparam int DW = 32;
    localparam int IW = 6;
    localparam int PS = 2;

    logic          clk;
    logic          arst;
    logic          inValid;
    logic          inReady;
    shift_op_t     op;
    logic          useImm;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [IW-1:0] imm;
    logic          outValid;
    logic          outReady;
    logic [DW-1:0] result;

    int nVectors     = 0;
    int nMiscompares = 0;
    int acceptCount  = 0;
    int outCount     = 0;
    logic [DW-1:0] expQ [$];

    alu_shift_pipe #(
        .DATA_WIDTH  (DW),
        .IMM_WIDTH   (IW),
        .PIPE_STAGES (PS)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .op_i        (op),
        .use_imm_i   (useImm),
        .rs1_data_i  (rs1),
        .rs2_data_i  (rs2),
        .imm_i       (imm),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shifter written from the operation definitions, not the mux structure.
    function automatic logic [DW-1:0] refShift(input logic [2:0] code, input logic [DW-1:0] value,
                                               input logic [DW-1:0] amount);
        int unsigned   n;
        logic [2*DW-1:0] doubled;
        logic [2*DW-1:0] moved;
        n       = amount % DW;
        doubled = {value, value};
        case (code)
            3'd0: return value << n;
            3'd2: return $unsigned($signed(value) >>> n);
            3'd3: begin moved = doubled >> (DW - n); return moved[DW-1:0]; end
            3'd4: begin moved = doubled >> n; return moved[DW-1:0]; end
            default: return value >> n;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%h, wanted 0x%h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Monitor: record accepted requests and check every presented result.
    always @(negedge clk) begin
        if (!arst) begin
            if (inValid && inReady) begin
                expQ.push_back(refShift(op, rs1, useImm ? DW'(imm) : rs2));
                acceptCount++;
            end
            if (outValid) begin
                if (expQ.size() == 0) begin
                    reportTimeout("unexpected result with empty scoreboard");
                end else begin
                    checkOutput("scoreboard result", result, expQ[0]);
                    if (outReady) begin
                        void'(expQ.pop_front());
                        outCount++;
                    end
                end
            end
        end
    end

    // Offer one request and hold it until accepted; called just after a rising edge.
    task automatic applyStimulus(input shift_op_t o, input logic ui, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [IW-1:0] im, output int waited);
        bit accepted;
        op = o; useImm = ui; rs1 = a; rs2 = b; imm = im; inValid = 1'b1;
        waited   = 0;
        accepted = 1'b0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = inReady;
            @(posedge clk);
            #1;
            if (!accepted) waited++;
        end
        if (!accepted) reportTimeout("request acceptance");
        inValid = 1'b0;
    endtask

    // Single request into an idle pipe: check latency and the exact result.
    task automatic runDirected(input string name, input shift_op_t o, input logic ui,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [IW-1:0] im, input logic [DW-1:0] expected);
        int w;
        int n;
        applyStimulus(o, ui, a, b, im, w);
        n = 1;
        while (!outValid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, " latency"}, DW'(n), DW'(PS));
        checkOutput(name, result, expected);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput(name, DW'(expQ.size()), '0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int stalls;
        int base;
        int seen;

        arst = 1'b1; inValid = 1'b0; op = SHIFT_SLL; useImm = 1'b0;
        rs1 = '0; rs2 = '0; imm = '0; outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", DW'(outValid), '0);
        checkOutput("reset result", result, '0);
        checkOutput("reset in_ready", DW'(inReady), 32'd1);
        arst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed shifts");
        runDirected("sll 31",    SHIFT_SLL, 1'b0, 32'h0000_0001, 32'd31,        6'h00, 32'h8000_0000);
        runDirected("sra imm 63",SHIFT_SRA, 1'b1, 32'h8000_0000, 32'h0,         6'h3F, 32'hFFFF_FFFF);
        runDirected("srl imm 63",SHIFT_SRL, 1'b1, 32'h8000_0000, 32'h0,         6'h3F, 32'h0000_0001);
        runDirected("ror 0x24",  SHIFT_ROR, 1'b0, 32'h1234_5678, 32'h0000_0024, 6'h00, 32'h8123_4567);
        runDirected("rol 0x24",  SHIFT_ROL, 1'b0, 32'h1234_5678, 32'h0000_0024, 6'h00, 32'h2345_6781);
        runDirected("op 7",      shift_op_t'(3'b111), 1'b0, 32'hF000_0000, 32'd4, 6'h00, 32'h0F00_0000);
        for (int i = 0; i < 8; i++) begin
            if (i < 5 || i == 7)
                runDirected("zero shift", shift_op_t'(i), 1'b0, 32'h1234_5678, 32'h0000_0040, 6'h00, 32'h1234_5678);
        end
        runDirected("zero imm",  SHIFT_SRA, 1'b1, 32'h9234_5678, 32'hFFFF_FFFF, 6'h20, 32'h9234_5678);

        $display("[TB] backpressure");
        outReady = 1'b0;
        base = acceptCount;
        fork
            begin
                applyStimulus(SHIFT_SLL, 1'b0, 32'h0000_00F1, 32'd8,  6'h00, w);
                applyStimulus(SHIFT_SRA, 1'b1, 32'h8765_4321, 32'd0,  6'h0C, w);
                applyStimulus(SHIFT_ROR, 1'b0, 32'hCAFE_BABE, 32'd17, 6'h00, w);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                checkOutput("stall in_ready", DW'(inReady), '0);
                checkOutput("stall accepted", DW'(acceptCount - base), 32'd2);
                outReady = 1'b1;
            end
        join
        waitDrain("backpressure drain");
        @(negedge clk);
        checkOutput("in_ready after drain", DW'(inReady), 32'd1);
        checkOutput("backpressure accepted", DW'(acceptCount - base), 32'd3);
        @(posedge clk);
        #1;

        $display("[TB] streaming");
        stalls = 0;
        seen   = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    applyStimulus(shift_op_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                  $urandom, $urandom, IW'($urandom_range(0, 63)), w);
                    stalls += w;
                end
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!outValid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (outValid) seen = 1;
                repeat (15) begin
                    @(negedge clk);
                    if (outValid) seen++;
                end
            end
        join
        checkOutput("stream stalls", DW'(stalls), '0);
        checkOutput("stream results per cycle", DW'(seen), 32'd16);
        waitDrain("stream drain");

        $display("[TB] reset mid-operation");
        outReady = 1'b0;
        applyStimulus(SHIFT_SLL, 1'b0, 32'h0000_0003, 32'd1, 6'h00, w);
        applyStimulus(SHIFT_ROL, 1'b0, 32'h8000_0001, 32'd1, 6'h00, w);
        checkOutput("in flight before reset", DW'(outValid), 32'd1);
        #1 arst = 1'b1;
        #1;
        checkOutput("mid reset out_valid", DW'(outValid), '0);
        checkOutput("mid reset result", result, '0);
        checkOutput("mid reset in_ready", DW'(inReady), 32'd1);
        expQ.delete();
        #1 arst = 1'b0;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        base = outCount;
        runDirected("after reset", SHIFT_SRL, 1'b0, 32'hA5A5_0000, 32'd16, 6'h00, 32'h0000_A5A5);
        waitDrain("post reset drain");
        checkOutput("post reset result count", DW'(outCount - base), 32'd1);

        checkOutput("scoreboard empty at end", DW'(expQ.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
